// File: rtl/btn_press_decoder.sv
// Button event decoder: turns a debounced button level into single-cycle
// press/release/short/long/repeat events plus a wrapping press counter.
module btn_press_decoder #(
   parameter int unsigned LONG_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000,
   parameter int unsigned CNT_W         = 25
) (
   input  logic       clockSource,
   input  logic       reset,
   input  logic       btnFiltered,
   output logic       pressEdge,
   output logic       releaseEdge,
   output logic       shortPress,
   output logic       longPress,
   output logic       repeatPulse,
   output logic       held,
   output logic [7:0] pressCount
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic             sync_a;
   logic             btn_sync;

   state_t           state;
   state_t           state_nxt;

   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_nxt;
   logic [CNT_W-1:0] rep_cnt;
   logic [CNT_W-1:0] rep_nxt;
   logic [7:0]       count_nxt;

   logic             press_nxt;
   logic             release_nxt;
   logic             short_nxt;
   logic             long_nxt;
   logic             repeat_nxt;
   logic             held_nxt;

   // Two-flop synchronizer; the level is async to this clock domain.
   always_ff @(posedge clockSource or posedge reset) begin
      if (reset) begin
         sync_a   <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         sync_a   <= btnFiltered;
         btn_sync <= sync_a;
      end
   end

   // State, counters and every output are registered together.
   always_ff @(posedge clockSource or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         rep_cnt     <= '0;
         pressCount  <= 8'd0;
         pressEdge   <= 1'b0;
         releaseEdge <= 1'b0;
         shortPress  <= 1'b0;
         longPress   <= 1'b0;
         repeatPulse <= 1'b0;
         held        <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_nxt;
         rep_cnt     <= rep_nxt;
         pressCount  <= count_nxt;
         pressEdge   <= press_nxt;
         releaseEdge <= release_nxt;
         shortPress  <= short_nxt;
         longPress   <= long_nxt;
         repeatPulse <= repeat_nxt;
         held        <= held_nxt;
      end
   end

   // Next state and pulses; release always wins over a threshold hit.
   always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      rep_nxt     = rep_cnt;
      count_nxt   = pressCount;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      short_nxt   = 1'b0;
      long_nxt    = 1'b0;
      repeat_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (btn_sync) begin
               state_nxt = PRESSED;
               press_nxt = 1'b1;
               hold_nxt  = '0;
               count_nxt = pressCount + 8'd1;
            end
         end
         PRESSED: begin
            if (!btn_sync) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
               short_nxt   = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = LONG;
               long_nxt  = 1'b1;
               rep_nxt   = '0;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         LONG: begin
            if (!btn_sync) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
            end else if (rep_cnt == REP_LAST) begin
               repeat_nxt = 1'b1;
               rep_nxt    = '0;
            end else begin
               rep_nxt = rep_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      held_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_btn_press_decoder.sv
// Scoreboard bench for btn_press_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Stimulus queues expected events; a negedge monitor pops and compares them.
module tb_btn_press_decoder;

   localparam int LC = 8;
   localparam int RC = 4;

   typedef struct {
      int         cyc;
      logic [4:0] ev;
      logic [7:0] cnt;
      logic       hld;
   } exp_t;

   localparam logic [4:0] EV_PRESS = 5'b10000;
   localparam logic [4:0] EV_REL   = 5'b01000;
   localparam logic [4:0] EV_SHORT = 5'b00100;
   localparam logic [4:0] EV_LONG  = 5'b00010;
   localparam logic [4:0] EV_REP   = 5'b00001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b0;
   logic       press_e;
   logic       rel_e;
   logic       short_p;
   logic       long_p;
   logic       rep_p;
   logic       held;
   logic [7:0] pcount;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   n_press = 0;
   int   n_short = 0;
   int   cnt_m = 0;
   exp_t sb[$];

   btn_press_decoder #(
      .LONG_CYCLES  (LC),
      .REPEAT_CYCLES(RC),
      .CNT_W        (4)
   ) dut (
      .clockSource(clk),
      .reset      (rst),
      .btnFiltered(btn),
      .pressEdge  (press_e),
      .releaseEdge(rel_e),
      .shortPress (short_p),
      .longPress  (long_p),
      .repeatPulse(rep_p),
      .held       (held),
      .pressCount (pcount)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every pulse the DUT shows must match the head of the queue.
   always @(negedge clk) begin
      logic [4:0] ev;
      exp_t       e;
      ev = {press_e, rel_e, short_p, long_p, rep_p};
      if (!rst && ev != 5'b0) begin
         if (press_e) n_press++;
         if (short_p) n_short++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d got ev=%b cnt=%0d",
                     cyc, ev, pcount);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.ev != ev || e.cnt != pcount ||
                e.hld != held) begin
               errors++;
               $display("FAIL event got cyc=%0d ev=%b cnt=%0d held=%b want cyc=%0d ev=%b cnt=%0d held=%b",
                        cyc, ev, pcount, held, e.cyc, e.ev, e.cnt, e.hld);
            end
         end
      end
   end

   task automatic push(input int c, input logic [4:0] ev, input logic h);
      exp_t e;
      e.cyc = c;
      e.ev  = ev;
      e.cnt = 8'(cnt_m);
      e.hld = h;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // Raise btn now, drop it after hold edges; queue everything that follows.
   task automatic press_hold(input int hold, input int gap);
      int e0;
      e0 = cyc + 3;
      cnt_m = (cnt_m + 1) % 256;
      push(e0, EV_PRESS, 1'b1);
      if (hold > LC) begin
         push(e0 + LC, EV_LONG, 1'b1);
         for (int t = e0 + LC + RC; t < e0 + hold; t += RC)
            push(t, EV_REP, 1'b1);
         push(e0 + hold, EV_REL, 1'b0);
      end else begin
         push(e0 + hold, EV_REL | EV_SHORT, 1'b0);
      end
      btn = 1'b1;
      tick(hold);
      btn = 1'b0;
      tick(gap);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn = 1'b0;
      cnt_m = 0;
      tick(3);
      rst = 1'b0;
      tick(2);
   endtask

   initial begin
      int e0;
      int p0;
      int s0;

      // 1: reset held with button down, then a press right after deassert
      btn = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("reset_outputs_zero",
               int'({press_e, rel_e, short_p, long_p, rep_p, held, pcount}),
               0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      press_hold(3, 6);
      check("t1_count", int'(pcount), 1);

      // 2: short press
      press_hold(5, 6);
      check("t2_held_low", int'(held), 0);

      // 3: long press with three repeats
      press_hold(21, 6);

      // 4: release lands exactly on the long threshold edge
      press_hold(LC, 6);
      check("t4_count", int'(pcount), 4);

      // 5: 257 presses wrap the counter
      do_reset();
      p0 = n_press;
      s0 = n_short;
      for (int i = 0; i < 257; i++)
         press_hold(1, 4);
      tick(4);
      check("t5_count_wrap", int'(pcount), 1);
      check("t5_press_pulses", n_press - p0, 257);
      check("t5_short_pulses", n_short - s0, 257);

      // 6: async reset while repeating
      e0 = cyc + 3;
      cnt_m = (cnt_m + 1) % 256;
      push(e0, EV_PRESS, 1'b1);
      push(e0 + LC, EV_LONG, 1'b1);
      push(e0 + LC + RC, EV_REP, 1'b1);
      btn = 1'b1;
      tick(16);
      check("t6_held_before", int'(held), 1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_clear",
            int'({press_e, rel_e, short_p, long_p, rep_p, held, pcount}),
            0);
      btn = 1'b0;
      cnt_m = 0;
      tick(3);
      rst = 1'b0;
      tick(12);
      check("t6_idle_held", int'(held), 0);
      check("t6_idle_count", int'(pcount), 0);
      check("queue_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
